// File: rtl/burst_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | burst_ram_arbiter                                                          |
// | Shares one burst RAM command port between two buffered cache clients.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module burst_ram_arbiter #(
  parameter int ADDR_BITWIDTH          = 21,
  parameter int BURST_BEATS            = 4,
  parameter int COMMAND_DELAY_INTERVAL = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     c0_cmd,
  input  logic                     c0_cmd_en,
  input  logic [ADDR_BITWIDTH-1:0] c0_addr,
  input  logic [63:0]              c0_wr_data,
  input  logic [7:0]               c0_data_mask,
  output logic [63:0]              c0_rd_data,
  output logic                     c0_rd_data_valid,
  output logic                     c0_busy,
  input  logic                     c1_cmd,
  input  logic                     c1_cmd_en,
  input  logic [ADDR_BITWIDTH-1:0] c1_addr,
  input  logic [63:0]              c1_wr_data,
  input  logic [7:0]               c1_data_mask,
  output logic [63:0]              c1_rd_data,
  output logic                     c1_rd_data_valid,
  output logic                     c1_busy,
  output logic                     br_cmd,
  output logic                     br_cmd_en,
  output logic [ADDR_BITWIDTH-1:0] br_addr,
  output logic [63:0]              br_wr_data,
  output logic [7:0]               br_data_mask,
  input  logic [63:0]              br_rd_data,
  input  logic                     br_rd_data_valid
);

  localparam int c_BEAT_W = $clog2(BURST_BEATS);
  localparam int c_DLY_W  = $clog2(COMMAND_DELAY_INTERVAL + 1);
  // Grant happens one cycle before the br_cmd_en pulse, hence the minus one.
  localparam logic [c_DLY_W-1:0] c_DLY_LOAD = c_DLY_W'(COMMAND_DELAY_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_1     = 3'd2,
    S_WR_2     = 3'd3,
    S_WR_3     = 3'd4,
    S_RD_ISSUE = 3'd5,
    S_RD_WAIT  = 3'd6
  } state_t;

  state_t r_state, w_state_nxt;

  logic [1:0]               w_cmd_en, w_cmd_in, w_cap, w_done, w_req;
  logic [ADDR_BITWIDTH-1:0] w_addr_in [2];
  logic [63:0]              w_data_in [2];
  logic [7:0]               w_mask_in [2];

  logic [1:0]               r_pend, r_cmd;
  logic [ADDR_BITWIDTH-1:0] r_addr [2];
  logic [7:0]               r_mask [2];
  logic [63:0]              r_slot [2][BURST_BEATS];
  logic [c_BEAT_W-1:0]      r_cap  [2];

  logic                     r_owner, r_last;
  logic [c_DLY_W-1:0]       r_dly;
  logic [1:0]               r_rd_cnt;
  logic                     r_br_cmd_en, r_br_cmd;
  logic [ADDR_BITWIDTH-1:0] r_br_addr;
  logic [7:0]               r_br_mask;

  logic                     w_gnt_vld, w_gnt_id, w_gnt_cmd;
  logic [ADDR_BITWIDTH-1:0] w_gnt_addr;
  logic [7:0]               w_gnt_mask;

  assign w_cmd_en     = {c1_cmd_en, c0_cmd_en};
  assign w_cmd_in     = {c1_cmd, c0_cmd};
  assign w_addr_in[0] = c0_addr;
  assign w_addr_in[1] = c1_addr;
  assign w_data_in[0] = c0_wr_data;
  assign w_data_in[1] = c1_wr_data;
  assign w_mask_in[0] = c0_data_mask;
  assign w_mask_in[1] = c1_data_mask;
  assign w_cap        = w_cmd_en & ~r_pend;

  // Per-client command buffers; write beats 1..3 follow the command pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_cmd  <= '0;
      for (int i = 0; i < 2; i++) begin
        r_addr[i] <= '0;
        r_mask[i] <= '0;
        r_cap[i]  <= '0;
        for (int k = 0; k < BURST_BEATS; k++) r_slot[i][k] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_cap[i]) begin
          r_pend[i]    <= 1'b1;
          r_cmd[i]     <= w_cmd_in[i];
          r_addr[i]    <= w_addr_in[i];
          r_mask[i]    <= w_mask_in[i];
          r_slot[i][0] <= w_data_in[i];
          r_cap[i]     <= w_cmd_in[i] ? c_BEAT_W'(1) : '0;
        end else begin
          if (w_done[i]) r_pend[i] <= 1'b0;
          if (r_cap[i] != '0) begin
            r_slot[i][r_cap[i]] <= w_data_in[i];
            r_cap[i]            <= r_cap[i] + c_BEAT_W'(1);
          end
        end
      end
    end
  end

  // A command arriving this cycle competes directly so it can issue next cycle.
  assign w_req      = r_pend | w_cmd_en;
  assign w_gnt_vld  = (r_state == S_IDLE) && (r_dly == '0) && (w_req != 2'b00);
  assign w_gnt_id   = (&w_req) ? ~r_last : w_req[1];
  assign w_gnt_cmd  = r_pend[w_gnt_id] ? r_cmd[w_gnt_id]  : w_cmd_in[w_gnt_id];
  assign w_gnt_addr = r_pend[w_gnt_id] ? r_addr[w_gnt_id] : w_addr_in[w_gnt_id];
  assign w_gnt_mask = r_pend[w_gnt_id] ? r_mask[w_gnt_id] : w_mask_in[w_gnt_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 2'b00;
    case (r_state)
      S_IDLE:     if (w_gnt_vld) w_state_nxt = w_gnt_cmd ? S_WR_ISSUE : S_RD_ISSUE;
      S_WR_ISSUE: w_state_nxt = S_WR_1;
      S_WR_1:     w_state_nxt = S_WR_2;
      S_WR_2:     w_state_nxt = S_WR_3;
      S_WR_3: begin
        w_state_nxt     = S_IDLE;
        w_done[r_owner] = 1'b1;
      end
      S_RD_ISSUE: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (br_rd_data_valid && (r_rd_cnt == 2'd3)) begin
          w_state_nxt     = S_IDLE;
          w_done[r_owner] = 1'b1;
        end
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_dly       <= '0;
      r_rd_cnt    <= '0;
      r_br_cmd_en <= 1'b0;
      r_br_cmd    <= 1'b0;
      r_br_addr   <= '0;
      r_br_mask   <= '0;
    end else begin
      r_br_cmd_en <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_owner   <= w_gnt_id;
        r_last    <= w_gnt_id;
        r_dly     <= c_DLY_LOAD;
        r_rd_cnt  <= '0;
        r_br_cmd  <= w_gnt_cmd;
        r_br_addr <= w_gnt_addr;
        r_br_mask <= w_gnt_mask;
      end else begin
        if (r_dly != '0) r_dly <= r_dly - c_DLY_W'(1);
        if ((r_state == S_RD_WAIT) && br_rd_data_valid) r_rd_cnt <= r_rd_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    br_wr_data = '0;
    case (r_state)
      S_WR_ISSUE: br_wr_data = r_slot[r_owner][0];
      S_WR_1:     br_wr_data = r_slot[r_owner][1];
      S_WR_2:     br_wr_data = r_slot[r_owner][2];
      S_WR_3:     br_wr_data = r_slot[r_owner][3];
      default:    br_wr_data = '0;
    endcase
  end

  assign br_cmd_en        = r_br_cmd_en;
  assign br_cmd           = r_br_cmd;
  assign br_addr          = r_br_addr;
  assign br_data_mask     = r_br_mask;
  assign c0_busy          = r_pend[0];
  assign c1_busy          = r_pend[1];
  assign c0_rd_data       = br_rd_data;
  assign c1_rd_data       = br_rd_data;
  assign c0_rd_data_valid = br_rd_data_valid && (r_state == S_RD_WAIT) && !r_owner;
  assign c1_rd_data_valid = br_rd_data_valid && (r_state == S_RD_WAIT) &&  r_owner;

endmodule
`default_nettype wire
